// File: rtl/sorted_vector_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sorted_vector_serializer
// Purpose  : Captures one sorted N-element vector and streams it out one
//            element per cycle with index/last flags. Optional run-dedup via
//            macro SORTED_SERIALIZER_DEDUP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sorted_vector_serializer #(
  parameter int N           = 16,
  parameter int log_N       = 4,
  parameter int INPUT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [0:N*INPUT_WIDTH-1]   in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INPUT_WIDTH-1:0]     out,
  output logic [log_N-1:0]           out_idx,
  output logic                       out_last
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [INPUT_WIDTH-1:0] r_buf [N];
  logic [log_N-1:0]       r_count;
  logic [log_N-1:0]       w_count_nxt;
  logic                   w_last;
  logic                   w_in_hs;
  logic                   w_out_hs;

`ifdef SORTED_SERIALIZER_DEDUP_EN
  logic [N-1:0] r_keep;
  logic [N-1:0] w_keep_cap;
  logic         w_found;

  // Keep marks the first element of each run of equal values; the priority
  // encoder picks the lowest kept index above count so runs are skipped
  // without bubbles.
  always_comb begin
    w_keep_cap    = '0;
    w_keep_cap[0] = 1'b1;
    for (int k = 1; k < N; k++) begin
      w_keep_cap[k] = (in[k*INPUT_WIDTH +: INPUT_WIDTH] !=
                       in[(k-1)*INPUT_WIDTH +: INPUT_WIDTH]);
    end
    w_found     = 1'b0;
    w_count_nxt = r_count;
    for (int k = N-1; k >= 0; k--) begin
      if (r_keep[k] && (k > int'(r_count))) begin
        w_found     = 1'b1;
        w_count_nxt = log_N'(k);
      end
    end
  end

  assign w_last = ~w_found;
`else
  assign w_count_nxt = r_count + log_N'(1);
  assign w_last      = (r_count == log_N'(N-1));
`endif

  assign w_in_hs  = in_valid & in_ready;
  assign w_out_hs = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // in_ready depends combinationally on out_ready so a new vector can be
  // taken on the final handshake of the current one.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        out_valid = 1'b1;
        in_ready  = w_last & out_ready;
        if (out_ready && w_last && !in_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out      = '0;
    out_idx  = '0;
    out_last = 1'b0;
    if (r_state == S_STREAM) begin
      out      = r_buf[r_count];
      out_idx  = r_count;
      out_last = w_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      for (int k = 0; k < N; k++) begin
        r_buf[k] <= '0;
      end
`ifdef SORTED_SERIALIZER_DEDUP_EN
      r_keep <= '0;
`endif
    end else if (w_in_hs) begin
      r_count <= '0;
      for (int k = 0; k < N; k++) begin
        r_buf[k] <= in[k*INPUT_WIDTH +: INPUT_WIDTH];
      end
`ifdef SORTED_SERIALIZER_DEDUP_EN
      r_keep <= w_keep_cap;
`endif
    end else if (w_out_hs && !w_last) begin
      r_count <= w_count_nxt;
    end
  end

endmodule
`default_nettype wire
